// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetches, buffers in-order
// responses and hands {pc, instr} to decode; redirects flush and restart at the target.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = 8;

   logic [31:0]   req_pc;
   logic [31:0]   rsp_pc;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_next;
   logic [OW-1:0] stale;
   logic [OW-1:0] live;
   logic [OW-1:0] occupancy;
   logic [CW-1:0] count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   buf_pc   [DEPTH];
   logic [31:0]   buf_word [DEPTH];
   logic [31:0]   redirect_target;
   logic          pop;
   logic          req_fire;
   logic          rsp_live;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign redirect_target = redirect_pc & ~32'h3;
   assign live            = outstanding - stale;
   assign instr_valid     = (count != '0);
   assign pop             = instr_valid & instr_ready;

   // Live fetches plus buffered entries never exceed DEPTH, so every live response has a slot.
   assign occupancy       = live + OW'(count) - OW'(pop);
   assign imem_req_valid  = !redirect_valid && (occupancy < OW'(DEPTH));
   assign imem_req_addr   = req_pc;
   assign req_fire        = imem_req_valid & imem_req_ready;
   assign rsp_live        = imem_rsp_valid && (stale == '0) && !redirect_valid;

   assign instr           = buf_word[head];
   assign instr_pc        = buf_pc[head];
   assign instr_pc_plus4  = buf_pc[head] + 32'd4;

   always_comb begin
      outstanding_next = outstanding;
      if (req_fire)
         outstanding_next = outstanding_next + 1'b1;
      if (imem_rsp_valid && (outstanding != '0))
         outstanding_next = outstanding_next - 1'b1;
   end

   // On redirect every fetch still in flight becomes stale and is dropped as it returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc      <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         stale       <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_pc[i]   <= '0;
            buf_word[i] <= '0;
         end
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            req_pc <= redirect_target;
            rsp_pc <= redirect_target;
            stale  <= outstanding_next;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
         end else begin
            if (req_fire)
               req_pc <= req_pc + 32'd4;
            if (imem_rsp_valid && (stale != '0))
               stale <= stale - 1'b1;
            if (rsp_live) begin
               buf_pc[tail]   <= rsp_pc;
               buf_word[tail] <= imem_rsp_data;
               tail           <= bump(tail);
               rsp_pc         <= rsp_pc + 32'd4;
            end
            if (pop)
               head <= bump(head);
            count <= count + CW'(rsp_live) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a tagged in-order memory model plus an expected-instruction queue
// check every delivered {pc, instr}, the request stream and the request gating each cycle.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 2;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } flight_t;

   flight_t     memQ[$];
   logic [31:0] bufQ[$];
   logic [31:0] expReqPc;
   logic [31:0] expRspPc;
   int          epoch;
   int          cyc;
   int          nVec;
   int          nErr;
   int          readyPct;
   int          memReadyPct;
   int          redirectPct;
   int          latMin;
   int          latMax;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic int liveCount();
      int n = 0;
      foreach (memQ[i])
         if (memQ[i].epoch == epoch)
            n++;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp)
      else begin
         nErr++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic driveMemRsp();
      if (memQ.size() != 0 && memQ[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memWord(memQ[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   // Check outputs at the falling edge, then advance the model across the rising edge.
   task automatic clockCycle();
      logic        popNow;
      logic        redirNow;
      logic        fireNow;
      logic        rspNow;
      logic        expReqValid;
      logic [31:0] fireAddr;
      logic [31:0] redirTarget;
      flight_t     r;
      flight_t     f;
      int          occ;
      @(negedge clk);
      popNow      = (bufQ.size() != 0) && instr_ready;
      redirNow    = redirect_valid;
      occ         = liveCount() + bufQ.size() - (popNow ? 1 : 0);
      expReqValid = !redirNow && (occ < DEPTH);
      checkOutput("instr_valid", 32'(instr_valid), 32'(bufQ.size() != 0));
      if (bufQ.size() != 0) begin
         checkOutput("instr_pc", instr_pc, bufQ[0]);
         checkOutput("instr", instr, memWord(bufQ[0]));
         checkOutput("instr_pc_plus4", instr_pc_plus4, bufQ[0] + 32'd4);
      end
      checkOutput("imem_req_valid", 32'(imem_req_valid), 32'(expReqValid));
      if (imem_req_valid)
         checkOutput("imem_req_addr", imem_req_addr, expReqPc);
      fireNow     = imem_req_valid && imem_req_ready;
      fireAddr    = imem_req_addr;
      rspNow      = imem_rsp_valid;
      redirTarget = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      if (popNow)
         void'(bufQ.pop_front());
      if (rspNow) begin
         r = memQ.pop_front();
         if (!redirNow && r.epoch == epoch) begin
            bufQ.push_back(expRspPc);
            expRspPc += 32'd4;
         end
      end
      if (redirNow) begin
         bufQ.delete();
         epoch++;
         expReqPc = redirTarget;
         expRspPc = redirTarget;
      end
      if (fireNow) begin
         f.addr  = fireAddr;
         f.epoch = epoch;
         f.due   = cyc + int'($urandom_range(latMax, latMin));
         memQ.push_back(f);
         expReqPc += 32'd4;
      end
      checkOutput("no_overflow", 32'(bufQ.size() <= DEPTH), 32'd1);
      cyc++;
      #1;
      redirect_valid = 1'b0;
      driveMemRsp();
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         instr_ready    = ($urandom_range(99, 0) < readyPct);
         imem_req_ready = ($urandom_range(99, 0) < memReadyPct);
         if ($urandom_range(99, 0) < redirectPct) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
         end
         clockCycle();
      end
   endtask

   task automatic doRedirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      clockCycle();
   endtask

   // Memory shares the reset, so anything it had in flight is forgotten too.
   task automatic doReset();
      #1;
      rst_n          = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      #1;
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_instr_pc", instr_pc, 32'd0);
      checkOutput("rst_instr_pc_plus4", instr_pc_plus4, 32'd4);
      memQ.delete();
      bufQ.delete();
      epoch++;
      expReqPc = RESET_PC;
      expRspPc = RESET_PC;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      nVec           = 0;
      nErr           = 0;
      epoch          = 0;
      cyc            = 0;
      latMin         = 1;
      latMax         = 1;
      readyPct       = 100;
      memReadyPct    = 100;
      redirectPct    = 0;
      expReqPc       = RESET_PC;
      expRspPc       = RESET_PC;

      @(posedge clk);
      doReset();

      $display("[TB] sequential fetch");
      applyStimulus(12);

      $display("[TB] decode backpressure");
      readyPct = 0;
      applyStimulus(10);
      readyPct = 100;
      applyStimulus(6);

      $display("[TB] memory stall");
      memReadyPct = 0;
      applyStimulus(5);
      memReadyPct = 100;
      applyStimulus(4);

      $display("[TB] redirect with stale responses");
      latMin = 3;
      latMax = 3;
      applyStimulus(4);
      doRedirect(32'h0000_2003);
      applyStimulus(10);

      $display("[TB] redirect colliding with a response");
      latMin = 1;
      latMax = 1;
      applyStimulus(5);
      doRedirect(32'h0000_3000);
      applyStimulus(6);

      $display("[TB] reset mid-run");
      readyPct = 0;
      applyStimulus(4);
      doReset();
      readyPct = 100;
      applyStimulus(6);

      $display("[TB] pc wrap");
      doRedirect(32'hFFFF_FFFC);
      applyStimulus(6);

      $display("[TB] random traffic");
      readyPct    = 70;
      memReadyPct = 75;
      latMin      = 1;
      latMax      = 4;
      redirectPct = 4;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(500);
         doReset();
      end
      redirectPct = 0;
      applyStimulus(20);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
